// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared AES-128 definitions: S-box table, round constants, key word layout
// and the inverse key-schedule state encoding.
package aes_inv_key_schedule_pkg;

    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    // Word 0 occupies the most significant 32 bits of a 128-bit key.
    typedef struct packed {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT10,
        ST_SUB,
        ST_MIX
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for the step that produces round key `rnd` from rnd+1.
    function automatic logic [WORD_W-1:0] rcon(input logic [3:0] rnd);
        logic [7:0] value;
        case (rnd)
            4'd0:    value = 8'h01;
            4'd1:    value = 8'h02;
            4'd2:    value = 8'h04;
            4'd3:    value = 8'h08;
            4'd4:    value = 8'h10;
            4'd5:    value = 8'h20;
            4'd6:    value = 8'h40;
            4'd7:    value = 8'h80;
            4'd8:    value = 8'h1b;
            4'd9:    value = 8'h36;
            default: value = 8'h00;
        endcase
        return {value, 24'h000000};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] word);
        return {word[23:0], word[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword_reg.sv
// SubWord with a registered output: four forward S-box lookups, one-cycle latency.
module aes_subword_reg
    import aes_inv_key_schedule_pkg::*;
(
    input  logic              clk,
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_word
);

    // NOTE: pure datapath register; its value is only consumed one cycle after
    // it is loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_W / 8; i++) begin
            sub_word[8*i +: 8] <= SBOX[word[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: from the round-10 key, strobes round keys
// 10 down to 0, one backward expansion step every two cycles.
module aes_inv_key_schedule
    import aes_inv_key_schedule_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] last_key,
    output logic             busy,
    output logic             key_valid,
    output logic [3:0]       key_round,
    output logic [KEY_W-1:0] key_out,
    output logic             done
);

    state_t            state, state_nxt;
    key_t              cur_key, cur_key_nxt;
    logic [3:0]        rnd, rnd_nxt;
    logic [WORD_W-1:0] w1, w2, w3;
    logic [WORD_W-1:0] w1_nxt, w2_nxt, w3_nxt;
    logic              busy_nxt, key_valid_nxt, done_nxt;
    logic [3:0]        key_round_nxt;
    logic [KEY_W-1:0]  key_out_nxt;

    logic [WORD_W-1:0] step_w3;
    logic [WORD_W-1:0] sub_rot;
    logic [WORD_W-1:0] mix_w0;
    key_t              mix_key;

    // The last three words of the previous round key need no S-box, so they
    // are formed in SUB while RotWord(w3) goes through the lookup.
    assign step_w3 = cur_key.w3 ^ cur_key.w2;
    assign mix_w0  = cur_key.w0 ^ sub_rot ^ rcon(rnd);
    assign mix_key = '{w0: mix_w0, w1: w1, w2: w2, w3: w3};

    aes_subword_reg u_subword (
        .clk      (clk),
        .word     (rot_word(step_w3)),
        .sub_word (sub_rot)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        cur_key_nxt   = cur_key;
        rnd_nxt       = rnd;
        w1_nxt        = w1;
        w2_nxt        = w2;
        w3_nxt        = w3;
        busy_nxt      = (state != ST_IDLE);
        key_valid_nxt = 1'b0;
        done_nxt      = 1'b0;
        key_round_nxt = key_round;
        key_out_nxt   = key_out;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    cur_key_nxt = last_key;
                    rnd_nxt     = 4'd9;
                    state_nxt   = ST_EMIT10;
                end
            end
            ST_EMIT10: begin
                key_valid_nxt = 1'b1;
                key_round_nxt = 4'd10;
                key_out_nxt   = cur_key;
                state_nxt     = ST_SUB;
            end
            ST_SUB: begin
                w1_nxt    = cur_key.w1 ^ cur_key.w0;
                w2_nxt    = cur_key.w2 ^ cur_key.w1;
                w3_nxt    = step_w3;
                state_nxt = ST_MIX;
            end
            ST_MIX: begin
                cur_key_nxt   = mix_key;
                key_valid_nxt = 1'b1;
                key_round_nxt = rnd;
                key_out_nxt   = mix_key;
                if (rnd == 4'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    rnd_nxt   = rnd - 4'd1;
                    state_nxt = ST_SUB;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_key   <= '0;
            rnd       <= 4'd0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            key_round <= 4'd0;
            key_out   <= '0;
        end else begin
            state     <= state_nxt;
            cur_key   <= cur_key_nxt;
            rnd       <= rnd_nxt;
            w1        <= w1_nxt;
            w2        <= w2_nxt;
            w3        <= w3_nxt;
            busy      <= busy_nxt;
            key_valid <= key_valid_nxt;
            done      <= done_nxt;
            key_round <= key_round_nxt;
            key_out   <= key_out_nxt;
        end
    end

endmodule
